// File: rtl/imem_loader.sv
// Boot-time program loader: packs a little-endian byte stream into 32-bit words,
// writes them to instruction memory and holds the core in reset until the image is complete.
module imem_loader #(
  parameter int DEPTH_WORDS = 256,
  parameter int ADDR_W      = 8
) (
  input  logic              Clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [7:0]        in_byte,
  input  logic              in_last,
  output logic              in_ready,
  input  logic              reload,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_hold,
  output logic              load_done,
  output logic              load_err,
  output logic [ADDR_W:0]   word_count
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_COLLECT = 3'd1,
    ST_WRITE   = 3'd2,
    ST_DONE    = 3'd3,
    ST_ERROR   = 3'd4
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH_WORDS - 1);
  localparam logic [ADDR_W-1:0] IDX_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);

  state_t              state_r;
  state_t              state_next_s;
  logic [1:0]          byte_cnt_r;
  logic [31:0]         word_r;
  logic                last_r;
  logic [ADDR_W-1:0]   word_idx_r;
  logic [ADDR_W:0]     word_count_r;
  logic                in_ready_r;
  logic                imem_we_r;
  logic                core_hold_r;
  logic                load_done_r;
  logic                load_err_r;
  logic                accept_s;

  assign accept_s = in_valid & in_ready_r;

  // State register
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state decode
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_next_s = in_last ? ST_WRITE : ST_COLLECT;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_COLLECT: begin
        if (accept_s && (in_last || (byte_cnt_r == 2'd3))) begin
          state_next_s = ST_WRITE;
        end else begin
          state_next_s = ST_COLLECT;
        end
      end
      ST_WRITE: begin
        if (last_r) begin
          state_next_s = ST_DONE;
        end else if (word_idx_r == LAST_IDX) begin
          state_next_s = ST_ERROR;
        end else begin
          state_next_s = ST_COLLECT;
        end
      end
      ST_DONE, ST_ERROR: begin
        if (reload) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = state_r;
        end
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Word assembly, word index and session counters
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      byte_cnt_r   <= 2'd0;
      word_r       <= 32'd0;
      last_r       <= 1'b0;
      word_idx_r   <= '0;
      word_count_r <= '0;
    end else begin
      case (state_r)
        ST_IDLE, ST_COLLECT: begin
          if (accept_s) begin
            word_r[{byte_cnt_r, 3'b000} +: 8] <= in_byte;
            byte_cnt_r <= byte_cnt_r + 2'd1;
            last_r     <= in_last;
          end
        end
        ST_WRITE: begin
          // Clearing the word here is what zero-pads a short final word.
          word_r       <= 32'd0;
          byte_cnt_r   <= 2'd0;
          last_r       <= 1'b0;
          word_count_r <= word_count_r + CNT_ONE;
          if (word_idx_r != LAST_IDX) begin
            word_idx_r <= word_idx_r + IDX_ONE;
          end
        end
        ST_DONE, ST_ERROR: begin
          if (reload) begin
            byte_cnt_r   <= 2'd0;
            word_r       <= 32'd0;
            last_r       <= 1'b0;
            word_idx_r   <= '0;
            word_count_r <= '0;
          end
        end
        default: begin
          byte_cnt_r <= 2'd0;
          last_r     <= 1'b0;
        end
      endcase
    end
  end

  // Status outputs registered from the next state so they align with it
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      in_ready_r  <= 1'b1;
      imem_we_r   <= 1'b0;
      core_hold_r <= 1'b1;
      load_done_r <= 1'b0;
      load_err_r  <= 1'b0;
    end else begin
      in_ready_r  <= (state_next_s == ST_IDLE) || (state_next_s == ST_COLLECT);
      imem_we_r   <= (state_next_s == ST_WRITE);
      core_hold_r <= (state_next_s != ST_DONE);
      load_done_r <= (state_next_s == ST_DONE);
      load_err_r  <= (state_next_s == ST_ERROR);
    end
  end

  assign in_ready   = in_ready_r;
  assign imem_we    = imem_we_r;
  assign imem_addr  = word_idx_r;
  assign imem_wdata = word_r;
  assign core_hold  = core_hold_r;
  assign load_done  = load_done_r;
  assign load_err   = load_err_r;
  assign word_count = word_count_r;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized scoreboard bench for imem_loader: expected writes are queued from an
// image-level model and popped by an independent monitor on every imem_we pulse.
module tb_imem_loader;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic          Clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic [7:0]    in_byte;
  logic          in_last;
  logic          in_ready;
  logic          reload;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          core_hold;
  logic          load_done;
  logic          load_err;
  logic [AW:0]   word_count;

  imem_loader #(.DEPTH_WORDS(DEPTH), .ADDR_W(AW)) dut (
    .Clk(Clk), .reset(reset), .in_valid(in_valid), .in_byte(in_byte),
    .in_last(in_last), .in_ready(in_ready), .reload(reload),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .core_hold(core_hold), .load_done(load_done), .load_err(load_err),
    .word_count(word_count)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  wr_t         exp_q[$];
  logic [7:0]  img[$];
  int          checks = 0;
  int          errors = 0;
  logic        we_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the oldest expected write
  always @(negedge Clk) begin
    wr_t e;
    if (!reset) begin
      we_prev = 1'b0;
    end else begin
      if (imem_we) begin
        check("we_single_cycle", 32'(we_prev), 32'd0);
        check("hold_during_write", 32'(core_hold), 32'd1);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write actual addr=%h data=%h expected no write", imem_addr, imem_wdata);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", 32'(imem_addr), e.a);
          check("wr_data", imem_wdata, e.d);
        end
      end
      we_prev = imem_we;
    end
  end

  // Drive img; returns the number of bytes the DUT accepted
  task automatic send_image(input bit use_last, input bit reload_mid, output int acc);
    int n;
    acc = 0;
    for (int i = 0; i < img.size(); i++) begin
      while ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        @(negedge Clk);
      end
      in_valid = 1'b1;
      in_byte  = img[i];
      in_last  = use_last && (i == img.size() - 1);
      reload   = reload_mid && (i == 2);
      n = 0;
      while (!in_ready && n < 8) begin
        @(negedge Clk);
        reload = 1'b0;
        n++;
      end
      if (in_ready) begin
        @(negedge Clk);
        acc++;
      end
      reload = 1'b0;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic push_words(input int nacc, input int base);
    wr_t e;
    for (int w = 0; w < (nacc + 3) / 4; w++) begin
      e.a = 32'(w);
      e.d = 32'd0;
      for (int k = 0; k < 4; k++) begin
        if (4 * w + k < nacc) e.d = e.d | (32'(img[base + 4 * w + k]) << (8 * k));
      end
      exp_q.push_back(e);
    end
  endtask

  task automatic do_reload();
    reload = 1'b1;
    @(negedge Clk);
    reload = 1'b0;
    check("reload_in_ready", 32'(in_ready), 32'd1);
    check("reload_core_hold", 32'(core_hold), 32'd1);
    check("reload_done_clr", 32'(load_done), 32'd0);
    check("reload_err_clr", 32'(load_err), 32'd0);
    check("reload_count_clr", 32'(word_count), 32'd0);
  endtask

  // Full session: model, drive, then check end state
  task automatic run_image(input bit use_last, input bit reload_mid);
    int  nb, nacc, acc, n;
    bit  exp_err;
    nb      = img.size();
    exp_err = (nb > 4 * DEPTH) || !use_last;
    nacc    = (nb > 4 * DEPTH) ? 4 * DEPTH : nb;
    push_words(nacc, 0);
    send_image(use_last, reload_mid, acc);
    n = 0;
    while (!(load_done || load_err) && n < 30) begin
      @(negedge Clk);
      n++;
    end
    check("session_end_timeout", 32'(n < 30), 32'd1);
    check("bytes_accepted", 32'(acc), 32'(nacc));
    check("load_done", 32'(load_done), 32'(!exp_err));
    check("load_err", 32'(load_err), 32'(exp_err));
    check("core_hold_end", 32'(core_hold), 32'(exp_err));
    check("in_ready_end", 32'(in_ready), 32'd0);
    check("word_count", 32'(word_count), 32'((nacc + 3) / 4));
    check("writes_pending", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int acc;
    reset = 1'b0; in_valid = 1'b0; in_byte = 8'd0; in_last = 1'b0; reload = 1'b0;
    repeat (3) @(negedge Clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_core_hold", 32'(core_hold), 32'd1);
    check("rst_we", 32'(imem_we), 32'd0);
    check("rst_addr", 32'(imem_addr), 32'd0);
    check("rst_wdata", imem_wdata, 32'd0);
    check("rst_done", 32'(load_done), 32'd0);
    check("rst_err", 32'(load_err), 32'd0);
    reset = 1'b1;
    repeat (10) @(negedge Clk);
    check("idle_in_ready", 32'(in_ready), 32'd1);
    check("idle_core_hold", 32'(core_hold), 32'd1);
    check("idle_word_count", 32'(word_count), 32'd0);

    img = '{8'h13, 8'h00, 8'h00, 8'h00, 8'hB3, 8'h00, 8'h21, 8'h00};
    run_image(1'b1, 1'b0);
    do_reload();

    img = '{8'h93, 8'h01};
    run_image(1'b1, 1'b0);
    do_reload();

    img.delete();
    for (int i = 0; i < 20; i++) img.push_back(8'($urandom));
    run_image(1'b0, 1'b0);
    do_reload();

    // Reset mid-load: first word completes, the partial second word is dropped
    img = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    push_words(4, 0);
    send_image(1'b0, 1'b0, acc);
    check("mid_bytes_accepted", 32'(acc), 32'd6);
    reset = 1'b0;
    @(negedge Clk);
    check("mid_rst_count", 32'(word_count), 32'd0);
    check("mid_rst_wdata", imem_wdata, 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check("mid_rst_hold", 32'(core_hold), 32'd1);
    reset = 1'b1;
    check("mid_writes_pending", 32'(exp_q.size()), 32'd0);
    img = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    run_image(1'b1, 1'b0);
    do_reload();

    img = '{8'h73, 8'h00, 8'h00, 8'h00};
    run_image(1'b1, 1'b0);
    do_reload();

    img = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
    run_image(1'b1, 1'b1);
    do_reload();

    for (int t = 0; t < 25; t++) begin
      int nb;
      nb = $urandom_range(1, 4 * DEPTH + 4);
      img.delete();
      for (int i = 0; i < nb; i++) img.push_back(8'($urandom));
      run_image(1'b1, t[0]);
      do_reload();
    end

    repeat (3) @(negedge Clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader for the pipelined RISC-V core. It accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words. Each word is written into instruction memory through a single write port. The core is held in reset until the whole image has been written. The block sits between the host/UART byte source and the `Processor` instruction memory, and drives the instruction side that the core otherwise only reads.

## Interface
Parameters:
- `DEPTH_WORDS`, 256: instruction memory capacity in 32-bit words (power of two).
- `ADDR_W`, 8: word-address width, equal to log2(`DEPTH_WORDS`).

Ports:
- `Clk`  in  1: the only clock; all state updates on the rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `in_valid`  in  1: the source has a byte available.
- `in_byte`  in  8: byte data.
- `in_last`  in  1: marks the final byte of the image; qualified by `in_valid`.
- `in_ready`  out  1: the loader can accept a byte.
- `reload`  in  1: single-cycle request to start a new load session.
- `imem_we`  out  1: instruction memory write strobe.
- `imem_addr`  out  ADDR_W: word address.
- `imem_wdata`  out  32: word to write.
- `core_hold`  out  1: high keeps the core in reset.
- `load_done`  out  1: image fully written.
- `load_err`  out  1: image exceeded `DEPTH_WORDS`.
- `word_count`  out  ADDR_W+1: number of words written this session.

## Operation
- A byte is accepted on a rising edge where `in_valid` and `in_ready` are both 1.
- States:
  - IDLE: `in_ready`=1; the first accepted byte moves to COLLECT.
  - COLLECT: `in_ready`=1; counts accepted bytes.
  - WRITE: `in_ready`=0; lasts exactly one cycle.
  - DONE: `in_ready`=0.
  - ERROR: `in_ready`=0.
- Byte placement: byte k (k=0..3) of each word goes to `imem_wdata[8k+7:8k]`, with the first byte in the LSBs.
- Entry to WRITE happens when either:
  - the 4th byte of a word is accepted, or
  - a byte with `in_last`=1 is accepted at any byte position. Unfilled upper bytes are zero-padded.
- In WRITE: `imem_we`=1, `imem_addr` = current word index, `imem_wdata` = assembled word.
- Leaving WRITE:
  - the word index increments and `word_count` increments;
  - if the word contained `in_last`, go to DONE;
  - else if the written index was `DEPTH_WORDS`-1, go to ERROR (the address never wraps);
  - otherwise return to COLLECT.
- DONE: `load_done`=1 and `core_hold`=0.
- ERROR: `load_err`=1 and `core_hold` stays 1.
- `reload`:
  - In DONE or ERROR it moves to IDLE and clears the byte counter, word index, `word_count`, `load_done` and `load_err`. `core_hold` returns to 1.
  - It is ignored in IDLE, COLLECT and WRITE.
- `in_last` on a byte that is not accepted has no effect.

## Timing
- Reset values: state IDLE, `in_ready`=1, `imem_we`=0, `imem_addr`=0, `imem_wdata`=0, `core_hold`=1, `load_done`=0, `load_err`=0, `word_count`=0.
- Reset asserted mid-load: all state returns to the reset values, and a partially assembled word is discarded without being written.
- `in_ready` is decoded from registered state only; it has no combinational path from `in_valid`.
- `imem_we` rises on the cycle after the edge that accepted the completing byte, is high for exactly one cycle, and is registered.
- `imem_addr` and `imem_wdata` are stable while `imem_we`=1.
- Throughput: one word per 5 cycles with `in_valid` held high (4 accept cycles plus 1 WRITE cycle).
- `core_hold` falls on the same edge that `load_done` rises: the edge leaving the final WRITE.
- `word_count` updates on the edge that leaves WRITE, so it equals the number of completed `imem_we` pulses.
- `reload` and the final WRITE cannot coincide because `reload` is ignored in WRITE; the session must reach DONE first.

## Test plan
- Reset release, `in_valid`=0 for 10 cycles: `in_ready`=1, `core_hold`=1, `imem_we` never asserted, `word_count`=0.
- Stream 0x13,0x00,0x00,0x00,0xB3,0x00,0x21,0x00 with `in_last` on the final byte:
  - writes addr 0 = 0x00000013 and addr 1 = 0x002100B3;
  - `load_done`=1, `core_hold`=0, `word_count`=2;
  - each `imem_we` is a 1-cycle pulse.
- Stream 0x93,0x01 with `in_last` on 0x01: a single write at addr 0 = 0x00000193; DONE with `word_count`=1.
- `DEPTH_WORDS`=4, 20 bytes with no `in_last`:
  - writes addr 0..3, then ERROR with `load_err`=1 and `core_hold`=1;
  - `in_ready`=0, bytes 17-20 are never accepted, and addr 0 is not rewritten.
- Assert `reset` after 6 bytes, then release and send 4 bytes 0xEF,0xBE,0xAD,0xDE with `in_last`: only addr 0 = 0xDEADBEEF is written, and `word_count`=1.
- From DONE, pulse `reload`, then load one word 0x00000073: `core_hold`=1 again during the load, then addr 0 = 0x00000073 and DONE with `word_count`=1.
- `reload` pulsed during COLLECT: ignored, and the load completes normally.
